// File: rtl/complex_div_pkg.sv
// Shared types and helpers for the packed complex divider.
// Default operand width, FSM state encoding and re/im unpacking helpers.
// Packing: upper half = real part, lower half = imaginary part.
package complex_div_pkg;

  localparam int N    = 32;
  localparam int HALF = N / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic signed [HALF-1:0] re(input logic [N-1:0] x);
    return x[N-1:HALF];
  endfunction

  function automatic logic signed [HALF-1:0] im(input logic [N-1:0] x);
    return x[HALF-1:0];
  endfunction

endpackage

// File: rtl/complex_div_if.sv
// Operand/result bus shared with the packed complex ALU.
// Master drives start/c/d; the divider (slave) drives status and result.
// start is only honoured while busy is low.
interface complex_div_if #(parameter int n = complex_div_pkg::N);
  logic         start;
  logic [n-1:0] c;
  logic [n-1:0] d;
  logic         busy;
  logic         done;
  logic [n-1:0] result;
  logic         div_zero;
  logic         ovf;

  modport master (output start, c, d, input busy, done, result, div_zero, ovf);
  modport slave  (input start, c, d, output busy, done, result, div_zero, ovf);
endinterface

// File: rtl/udiv_iter.sv
// Unsigned restoring divider: (n+1)-bit numerator / n-bit denominator.
// Latency: n+1 edges after the load edge, one quotient bit per edge.
// No backpressure; start reloads the datapath unconditionally.
module udiv_iter #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n:0]   num,
  input  logic [n-1:0] den,
  output logic         done,   // high in the cycle whose closing edge retires the last bit
  output logic [n:0]   quo     // quotient including the bit being retired this cycle
);
  localparam int CW = $clog2(n + 1);

  logic [n:0]    rem;
  logic [n:0]    qr;
  logic [n-1:0]  dv;
  logic [CW-1:0] cnt;
  logic          run;
  logic [n:0]    trial;
  logic [n:0]    rem_nxt;
  logic          ge;

  // One restoring step: shift in the next numerator bit, subtract if it fits.
  always_comb begin
    trial   = {rem[n-1:0], qr[n]};
    ge      = (trial >= {1'b0, dv});
    rem_nxt = ge ? (trial - {1'b0, dv}) : trial;
    quo     = {qr[n-1:0], ge};
    done    = run && (cnt == CW'(n));
  end

  // Load on start, then iterate n+1 times while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      qr  <= '0;
      dv  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      rem <= '0;
      qr  <= num;
      dv  <= den;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      rem <= rem_nxt;
      qr  <= quo;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/complex_div.sv
// Sequential complex divider: result = c / d, components truncated toward zero and saturated.
// Latency: n+3 cycles from the start edge to done (2 cycles when d == 0).
// start is ignored while busy; no queueing, no backpressure on the result.
module complex_div
  import complex_div_pkg::*;
#(
  parameter int n = N
) (
  input  logic clk,
  input  logic rst_n,
  complex_div_if.slave bus
);
  localparam int H = n / 2;
  localparam logic [n:0] LIM = {{(n+1-H){1'b0}}, 1'b1, {(H-1){1'b0}}};  // 2^(H-1)

  state_t              state;
  logic [n-1:0]        ca, cd;
  logic                re_neg, im_neg;
  logic                busy_q, done_q, dz_q, ovf_q;
  logic [n-1:0]        res_q;

  logic signed [n-1:0] ax, bx, ex, fx;
  logic signed [n-1:0] ae, bf, be, af, ee, ff;
  logic [n:0]          nre, nim, mre, mim;
  logic [n-1:0]        den;
  logic                div_go, dre_done, dim_done;
  logic [n:0]          qre, qim;
  logic [H:0]          sre, sim;

  // Clip a quotient magnitude to the signed H-bit range; MSB flags a clip.
  function automatic logic [H:0] sat(input logic [n:0] mag, input logic neg);
    logic [H:0] r;
    if (!neg && mag >= LIM)     r = {1'b1, 1'b0, {(H-1){1'b1}}};
    else if (neg && mag > LIM)  r = {1'b1, 1'b1, {(H-1){1'b0}}};
    else if (neg)               r = {1'b0, -mag[H-1:0]};
    else                        r = {1'b0, mag[H-1:0]};
    return r;
  endfunction

  // Products, numerators and denominator from the captured operands.
  always_comb begin
    ax  = {{H{ca[n-1]}}, ca[n-1:H]};
    bx  = {{H{ca[H-1]}}, ca[H-1:0]};
    ex  = {{H{cd[n-1]}}, cd[n-1:H]};
    fx  = {{H{cd[H-1]}}, cd[H-1:0]};
    ae  = ax * ex;
    bf  = bx * fx;
    be  = bx * ex;
    af  = ax * fx;
    ee  = ex * ex;
    ff  = fx * fx;
    nre = {ae[n-1], ae} + {bf[n-1], bf};
    nim = {be[n-1], be} - {af[n-1], af};
    den = ee + ff;
    mre = nre[n] ? -nre : nre;
    mim = nim[n] ? -nim : nim;
    div_go = (state == MUL) && (den != '0);
    sre = sat(qre, re_neg);
    sim = sat(qim, im_neg);
  end

  udiv_iter #(.n(n)) u_div_re (
    .clk(clk), .rst_n(rst_n), .start(div_go), .num(mre), .den(den),
    .done(dre_done), .quo(qre)
  );

  udiv_iter #(.n(n)) u_div_im (
    .clk(clk), .rst_n(rst_n), .start(div_go), .num(mim), .den(den),
    .done(dim_done), .quo(qim)
  );

  // Control FSM with registered status, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ca     <= '0;
      cd     <= '0;
      re_neg <= 1'b0;
      im_neg <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ca     <= bus.c;
            cd     <= bus.d;
            busy_q <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          re_neg <= nre[n];
          im_neg <= nim[n];
          if (den == '0) begin
            res_q <= '0;
            dz_q  <= 1'b1;
            ovf_q <= 1'b0;
            state <= DONE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          if (dre_done && dim_done) begin
            res_q <= {sre[H-1:0], sim[H-1:0]};
            dz_q  <= 1'b0;
            ovf_q <= sre[H] | sim[H];
            state <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.div_zero = dz_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_complex_div.sv
// Randomised bench for complex_div against a plain-arithmetic reference model.
// Timing expectations come from the start edge: done at +35 (or +2 when d == 0).
// A per-cycle compare process checks busy/done and the held result/flags.
module tb_complex_div;
  import complex_div_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  complex_div_if #(.n(32)) bus ();
  complex_div #(.n(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int e0 = -100;
  int done_at = -100;
  logic [31:0] pend_r, cur_r;
  logic pend_dz, pend_ov, cur_dz, cur_ov;
  bit have = 0;
  bit checking = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint clip(input longint q, inout logic ov);
    if (q > 32767) begin ov = 1'b1; return 32767; end
    if (q < -32768) begin ov = 1'b1; return -32768; end
    return q;
  endfunction

  // Reference: complex division by plain integer arithmetic (truncating toward zero).
  function automatic void model(input logic [31:0] cc, input logic [31:0] dd,
                                output logic [31:0] r, output logic dz, output logic ov);
    longint a, b, e, f, nr, ni, dn, qr, qi;
    a = longint'(re(cc)); b = longint'(im(cc));
    e = longint'(re(dd)); f = longint'(im(dd));
    nr = a * e + b * f;
    ni = b * e - a * f;
    dn = e * e + f * f;
    ov = 1'b0;
    if (dn == 0) begin
      r = '0; dz = 1'b1;
    end else begin
      qr = clip(nr / dn, ov);
      qi = clip(ni / dn, ov);
      r = {qr[15:0], qi[15:0]};
      dz = 1'b0;
    end
  endfunction

  // Per-cycle comparison of handshake and held outputs.
  always @(negedge clk) begin
    if (checking && rst_n) begin
      if (cyc == done_at) begin
        cur_r = pend_r; cur_dz = pend_dz; cur_ov = pend_ov; have = 1;
      end
      chk("busy", 32'(bus.busy), 32'(cyc >= e0 && cyc < done_at));
      chk("done", 32'(bus.done), 32'(cyc == done_at));
      if (have && !(cyc >= e0 && cyc < done_at)) begin
        chk("result", bus.result, cur_r);
        chk("div_zero", 32'(bus.div_zero), 32'(cur_dz));
        chk("ovf", 32'(bus.ovf), 32'(cur_ov));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called while idle, #1 after an edge; returns #1 after the start edge.
  task automatic start_op(input logic [31:0] cc, input logic [31:0] dd);
    bus.start = 1'b1; bus.c = cc; bus.d = dd;
    tick();
    e0 = cyc;
    model(cc, dd, pend_r, pend_dz, pend_ov);
    done_at = e0 + (pend_dz ? 2 : 35);
    bus.start = 1'b0;
    bus.c = $urandom;
    bus.d = $urandom;
  endtask

  task automatic wait_done();
    while (cyc < done_at + 1) tick();
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_result"}, bus.result, 32'd0);
    chk({nm, "_div_zero"}, 32'(bus.div_zero), 32'd0);
    chk({nm, "_ovf"}, 32'(bus.ovf), 32'd0);
  endtask

  logic [31:0] c1, d1, mr, rc, rd;
  logic mdz, mov;
  int mode, gap;

  initial begin
    rst_n = 1'b0; bus.start = 1'b0; bus.c = '0; bus.d = '0;
    c1 = {16'd100, 16'd50};
    d1 = {16'd3, 16'd4};
    repeat (3) tick();
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    cur_r = '0; cur_dz = 1'b0; cur_ov = 1'b0; have = 1; checking = 1;
    tick();

    // Hand-computed values pin the model.
    model(c1, d1, mr, mdz, mov);
    chk("model_t1", mr, 32'h0014FFF6);
    model({-16'sd7, 16'd0}, {16'd2, 16'd0}, mr, mdz, mov);
    chk("model_neg_trunc", mr, 32'hFFFD0000);
    model({16'h8000, 16'd0}, {16'd0, 16'd1}, mr, mdz, mov);
    chk("model_sat", {mr[31:1], mov}, {31'h00003FFF, 1'b1});

    // Basic division, 35-cycle latency checked by the compare process.
    start_op(c1, d1); wait_done();
    chk("t1_result", bus.result, 32'h0014FFF6);
    chk("t1_flags", {30'd0, bus.div_zero, bus.ovf}, 32'd0);

    // Truncation toward zero for both signs.
    start_op({-16'sd7, 16'd0}, {16'd2, 16'd0}); wait_done();
    chk("neg_trunc", bus.result, 32'hFFFD0000);
    start_op({16'd7, 16'd0}, {16'd2, 16'd0}); wait_done();
    chk("pos_trunc", bus.result, 32'h00030000);

    // Saturation of the imaginary component.
    start_op({16'h8000, 16'd0}, {16'd0, 16'd1}); wait_done();
    chk("sat_result", bus.result, 32'h00007FFF);
    chk("sat_ovf", 32'(bus.ovf), 32'd1);

    // Divide by zero, then a normal operation clears the flag.
    start_op(32'h12345678, 32'd0); wait_done();
    chk("dz_flag", 32'(bus.div_zero), 32'd1);
    chk("dz_result", bus.result, 32'd0);
    start_op(c1, d1); wait_done();
    chk("dz_cleared", 32'(bus.div_zero), 32'd0);

    // A second start pulse mid-operation is ignored.
    start_op(c1, d1);
    while (cyc < e0 + 4) tick();
    bus.start = 1'b1; bus.c = 32'h7FFF7FFF; bus.d = 32'h00010001;
    tick();
    bus.start = 1'b0;
    wait_done();
    chk("ignored_start", bus.result, 32'h0014FFF6);

    // Reset in flight abandons the operation.
    start_op({16'd7, 16'd0}, {16'd2, 16'd0});
    while (cyc < e0 + 9) tick();
    rst_n = 1'b0;
    e0 = -100; done_at = -100;
    cur_r = '0; cur_dz = 1'b0; cur_ov = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    tick(); tick();
    rst_n = 1'b1;
    repeat (40) tick();
    start_op(c1, d1); wait_done();
    chk("after_reset", bus.result, 32'h0014FFF6);

    // Start held high re-triggers on the first idle edge after done.
    bus.start = 1'b1; bus.c = {16'd7, 16'd0}; bus.d = {16'd2, 16'd0};
    tick();
    e0 = cyc; done_at = e0 + 35;
    model(bus.c, bus.d, pend_r, pend_dz, pend_ov);
    while (cyc < done_at + 1) tick();
    e0 = cyc; done_at = e0 + 35;
    bus.start = 1'b0;
    wait_done();
    chk("held_start", bus.result, 32'h00030000);

    // Randomised operations.
    for (int i = 0; i < 150; i++) begin
      mode = $urandom_range(0, 3);
      rc = $urandom;
      rd = $urandom;
      if (mode == 1)
        rd = {16'($urandom_range(0, 16) - 8), 16'($urandom_range(0, 16) - 8)};
      else if (mode == 2)
        rd = '0;
      else if (mode == 3) begin
        rc = {16'($urandom_range(0, 2000) - 1000), 16'($urandom_range(0, 2000) - 1000)};
        rd = {16'($urandom_range(0, 40) - 20), 16'($urandom_range(0, 40) - 20)};
      end
      start_op(rc, rd);
      wait_done();
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
    end

    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/complex_div.md
Name: complex_div

Overview:
- Sequential complex-number divider and companion to the packed complex ALU: computes result = c / d, where c and d are complex values.
- Operand packing matches the ALU: upper half is the real part, lower half is the imaginary part, both two's-complement integers.
- Uses one multiply cycle, then two parallel iterative restoring divisions sharing one denominator.
- Sits beside the ALU on the same operand/result bus, with a start/busy/done handshake.

Parameters:
n, 32, packed operand/result width; must be even; each component is n/2 bits signed.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request pulse; sampled only while idle.
c  input  n  dividend; {real a, imag b}.
d  input  n  divisor; {real e, imag f}.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; result and flags are valid from this cycle.
result  output  n  quotient; {real, imag}; held until the next done.
div_zero  output  1  set with done when e = f = 0.
ovf  output  1  set with done when either quotient component saturated.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, result, div_zero and ovf all 0; counter cleared. An operation in flight is abandoned and no done follows.
- Math, with H = n/2:
  - num_re = a*e + b*f, num_im = b*e - a*f, each H*2+1 bits signed.
  - den = e*e + f*f, n bits unsigned (maximum 2^(n-1) fits).
  - Quotient = magnitude(num) / den, restoring division, n+1 iterations.
  - Result is negated when num is negative, so quotients truncate toward zero.
- Saturation: each component saturates to [-2^(H-1), 2^(H-1)-1]. ovf = 1 if either component clipped.
- State machine (E0 = edge at which start is sampled high in IDLE):
  - IDLE: on E0, capture c and d; state MUL; busy = 1.
  - MUL: at E0+1, register the products, num_re, num_im and den.
    - If den == 0: go to DONE; result = 0, div_zero = 1, ovf = 0.
    - Else: go to DIV with count = 0.
  - DIV: one quotient bit per edge for both components, n+1 edges.
  - DONE: on the final DIV edge (E0+n+2), load result and flags.
    - done rises on edge E0+n+3 for exactly one cycle; busy falls on that same edge.
    - Latency is 35 cycles for n = 32, and 2 cycles on the div_zero path (done at E0+2).
  - Then return to IDLE.
- Flags: div_zero and ovf are updated only when done pulses, and hold their value until the next done.
- start while busy is ignored; it is not queued.
- start held high continuously re-triggers on the first idle edge after done.
- c and d may change freely after E0, since they were captured at E0.

Decomposition:
- Shared package holds:
  - state encoding IDLE/MUL/DIV/DONE;
  - the HALF = n/2 constant;
  - the packing helpers: re = upper half, im = lower half.
- One natural sub-module, udiv_iter: unsigned restoring divider taking an (n+1)-bit numerator and an n-bit denominator, one bit per clock, with start/done.
  - Instantiate it twice, once for the real component and once for the imaginary component; both run in lockstep.

Test Plan:
- c = {16'd100, 16'd50}, d = {16'd3, 16'd4} -> done exactly 35 cycles after the start edge; result = 32'h0014FFF6 (20 - 10j); div_zero = 0, ovf = 0.
- c = {-16'd7, 16'd0}, d = {16'd2, 16'd0} -> result = 32'hFFFD0000 (-3, truncated toward zero); c = {16'd7, 16'd0} with the same d -> result = 32'h00030000.
- c = {16'h8000, 16'd0}, d = {16'd0, 16'd1} -> imaginary component would be 32768; result = 32'h00007FFF with ovf = 1.
- d = 0 with any c -> done 2 cycles after start; result = 0, div_zero = 1; a following normal operation clears div_zero.
- Pulse start again at cycle 5 of an operation -> ignored; exactly one done pulse at cycle 35 with the first operation's result.
- Pull rst_n low at cycle 10 of an operation -> busy, done, result and flags all 0 immediately, with no done pulse; after release, a new start completes in 35 cycles.
